// File: rtl/powlib_sfifo_pkg.sv
// powlib_sfifo_pkg: shared constants and helpers for the synchronous FIFO slice.
//   powlib_clogb2(value) : ceiling log2, minimum 1, usable in parameter expressions
//   SFIFO_W_DEFAULT      : default data width
//   SFIFO_D_DEFAULT      : default depth in words
package powlib_sfifo_pkg;

    localparam int unsigned SFIFO_W_DEFAULT = 32;
    localparam int unsigned SFIFO_D_DEFAULT = 8;

    // Index width for a table of 'value' entries; never returns less than 1.
    function automatic int unsigned powlib_clogb2(input int unsigned value);
        int unsigned r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if (((value - 1) >> i) != 0) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/powlib_sfifo_if.sv
// powlib_sfifo_if: producer/consumer handshake bundle of the synchronous FIFO.
//   in_data/in_vld/in_rdy    : write side
//   out_data/out_vld/out_rdy : read side (first word falls through)
//   clr                      : synchronous flush
//   count/afull              : fill level and almost-full flag
//   modport master : the environment driving the FIFO
//   modport slave  : the FIFO itself
interface powlib_sfifo_if #(
    parameter int unsigned W  = 32,
    parameter int unsigned CW = 4
);
    logic [W-1:0]  in_data;
    logic          in_vld;
    logic          in_rdy;
    logic [W-1:0]  out_data;
    logic          out_vld;
    logic          out_rdy;
    logic          clr;
    logic [CW-1:0] count;
    logic          afull;

    modport master (
        output in_data, in_vld, out_rdy, clr,
        input  in_rdy, out_data, out_vld, count, afull
    );

    modport slave (
        input  in_data, in_vld, out_rdy, clr,
        output in_rdy, out_data, out_vld, count, afull
    );
endinterface

// File: rtl/powlib_sfifo_dpram.sv
// powlib_dpram: simple dual-port RAM, one synchronous write port and one
// combinational read port. Contents are not reset.
//   clk    : write clock
//   wridx  : write address
//   wrvld  : write enable
//   wrdata : write data
//   wrbe   : byte enables, honoured only when EWBE=1
//   rdidx  : read address
//   rddata : mem[rdidx], combinational
module powlib_dpram
    import powlib_sfifo_pkg::*;
#(
    parameter int unsigned W    = 32,
    parameter int unsigned D    = 8,
    parameter int unsigned EWBE = 0
) (
    input  logic                        clk,
    input  logic [powlib_clogb2(D)-1:0] wridx,
    input  logic                        wrvld,
    input  logic [W-1:0]                wrdata,
    input  logic [(W+7)/8-1:0]          wrbe,
    input  logic [powlib_clogb2(D)-1:0] rdidx,
    output logic [W-1:0]                rddata
);

    logic [W-1:0] mem [D];
    logic [W-1:0] mask;

    // Expand byte enables to a bit mask; all bits enabled when byte enables are off.
    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(W); i++) begin
            mask[i] = (EWBE == 0) ? 1'b1 : wrbe[i/8];
        end
    end

    // Masked write port.
    always_ff @(posedge clk) begin
        if (wrvld) begin
            mem[wridx] <= (mem[wridx] & ~mask) | (wrdata & mask);
        end
    end

    // Combinational read port.
    assign rddata = mem[rdidx];

endmodule

// File: rtl/powlib_sfifo.sv
// powlib_sfifo: single-clock first-word-fall-through FIFO with valid/ready on
// both sides, built on powlib_dpram with wrap-bit read/write pointers.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (pointers, count, afull)
//   bus : powlib_sfifo_if.slave
//         in_data/in_vld/in_rdy, out_data/out_vld/out_rdy, clr, count, afull
module powlib_sfifo
    import powlib_sfifo_pkg::*;
#(
    parameter int unsigned W    = SFIFO_W_DEFAULT,
    parameter int unsigned D    = SFIFO_D_DEFAULT,
    parameter int unsigned WIDX = powlib_clogb2(D),
    parameter int unsigned AFT  = D - 2
) (
    input  logic            clk,
    input  logic            rst,
    powlib_sfifo_if.slave   bus
);

    localparam int unsigned PW  = WIDX + 1;
    localparam int unsigned BEW = (W + 7) / 8;

    logic [PW-1:0] wrptr;
    logic [PW-1:0] rdptr;
    logic [PW-1:0] count_q;
    logic          afull_q;

    logic          empty;
    logic          full;
    logic          wr;
    logic          rd;
    logic [PW-1:0] wrptr_nxt;
    logic [PW-1:0] rdptr_nxt;
    logic [PW-1:0] count_nxt;

    // Equal pointers mean empty; same index on opposite laps means full.
    assign empty = (wrptr == rdptr);
    assign full  = (wrptr[WIDX] != rdptr[WIDX]) &&
                   (wrptr[WIDX-1:0] == rdptr[WIDX-1:0]);

    assign wr = bus.in_vld & ~full;
    assign rd = ~empty & bus.out_rdy;

    // Next pointer/count values; a flush overrides any transfer in the same cycle.
    always_comb begin
        wrptr_nxt = wrptr;
        rdptr_nxt = rdptr;
        count_nxt = count_q;
        if (bus.clr) begin
            wrptr_nxt = '0;
            rdptr_nxt = '0;
            count_nxt = '0;
        end else begin
            wrptr_nxt = wrptr + PW'(wr);
            rdptr_nxt = rdptr + PW'(rd);
            count_nxt = count_q + PW'(wr) - PW'(rd);
        end
    end

    // Pointers, count and almost-full flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrptr   <= '0;
            rdptr   <= '0;
            count_q <= '0;
            afull_q <= (AFT == 0);
        end else begin
            wrptr   <= wrptr_nxt;
            rdptr   <= rdptr_nxt;
            count_q <= count_nxt;
            afull_q <= (32'(count_nxt) >= AFT);
        end
    end

    powlib_dpram #(
        .W    (W),
        .D    (D),
        .EWBE (0)
    ) u_ram (
        .clk    (clk),
        .wridx  (wrptr[WIDX-1:0]),
        .wrvld  (wr & ~bus.clr),
        .wrdata (bus.in_data),
        .wrbe   ({BEW{1'b1}}),
        .rdidx  (rdptr[WIDX-1:0]),
        .rddata (bus.out_data)
    );

    assign bus.in_rdy  = ~full;
    assign bus.out_vld = ~empty;
    assign bus.count   = count_q;
    assign bus.afull   = afull_q;

endmodule

// File: tb/tb_powlib_sfifo.sv
// tb_powlib_sfifo: directed self-checking bench for powlib_sfifo (W=32, D=8, AFT=6).
module tb_powlib_sfifo;

    localparam int unsigned W   = 32;
    localparam int unsigned D   = 8;
    localparam int unsigned AFT = 6;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    powlib_sfifo_if #(.W(W), .CW(4)) bus ();

    powlib_sfifo #(.W(W), .D(D), .WIDX(3), .AFT(AFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge and let outputs settle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_vld = 1'b0; bus.in_data = '0; bus.out_rdy = 1'b0; bus.clr = 1'b0;
        #1;
        total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
        total++; if (bus.in_rdy !== 1'b1) begin bad++; $display("FAIL reset_in_rdy got=%b want=1", bus.in_rdy); end
        total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL reset_out_vld got=%b want=0", bus.out_vld); end
        total++; if (bus.afull !== 1'b0) begin bad++; $display("FAIL reset_afull got=%b want=0", bus.afull); end
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_midstream_reset();
        bus.in_vld = 1'b1; bus.out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = 32'h10 + 32'(i);
            cyc();
        end
        bus.in_vld = 1'b0;
        total++; if (bus.count !== 4'd5) begin bad++; $display("FAIL mrst_pre_count got=%0d want=5", bus.count); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL mrst_out_vld got=%b want=0", bus.out_vld); end
        total++; if (bus.in_rdy !== 1'b1) begin bad++; $display("FAIL mrst_in_rdy got=%b want=1", bus.in_rdy); end
        total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL mrst_count got=%0d want=0", bus.count); end
        @(negedge clk);
        rst = 1'b0;
        bus.in_vld = 1'b1; bus.in_data = 32'hA1;
        cyc();
        bus.in_vld = 1'b0;
        total++; if (bus.out_vld !== 1'b1) begin bad++; $display("FAIL mrst_a1_vld got=%b want=1", bus.out_vld); end
        total++; if (bus.out_data !== 32'hA1) begin bad++; $display("FAIL mrst_a1_data got=%h want=a1", bus.out_data); end
        bus.out_rdy = 1'b1;
        cyc();
        bus.out_rdy = 1'b0;
        total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL mrst_drain_vld got=%b want=0", bus.out_vld); end
    endtask

    task automatic test_fill_drain();
        logic exp_afull;
        logic exp_rdy;
        bus.in_vld = 1'b1; bus.out_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = 32'(i);
            cyc();
            exp_afull = (i + 1 >= int'(AFT));
            exp_rdy   = (i + 1 < int'(D));
            total++; if (bus.count !== 4'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d want=%0d", i, bus.count, i + 1); end
            total++; if (bus.afull !== exp_afull) begin bad++; $display("FAIL fill_afull[%0d] got=%b want=%b", i, bus.afull, exp_afull); end
            total++; if (bus.in_rdy !== exp_rdy) begin bad++; $display("FAIL fill_in_rdy[%0d] got=%b want=%b", i, bus.in_rdy, exp_rdy); end
        end
        bus.in_data = 32'h99;
        cyc();
        bus.in_vld = 1'b0;
        total++; if (bus.count !== 4'd8) begin bad++; $display("FAIL fill_ninth_count got=%0d want=8", bus.count); end
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (bus.out_vld !== 1'b1) begin bad++; $display("FAIL drain_vld[%0d] got=%b want=1", i, bus.out_vld); end
            total++; if (bus.out_data !== 32'(i)) begin bad++; $display("FAIL drain_data[%0d] got=%h want=%h", i, bus.out_data, 32'(i)); end
            cyc();
        end
        bus.out_rdy = 1'b0;
        total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", bus.out_vld); end
        total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL drain_count got=%0d want=0", bus.count); end
    endtask

    task automatic test_latency();
        bus.in_vld = 1'b1; bus.in_data = 32'h55; bus.out_rdy = 1'b0;
        #1;
        total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL lat_before got=%b want=0", bus.out_vld); end
        cyc();
        bus.in_vld = 1'b0;
        total++; if (bus.out_vld !== 1'b1) begin bad++; $display("FAIL lat_after_vld got=%b want=1", bus.out_vld); end
        total++; if (bus.out_data !== 32'h55) begin bad++; $display("FAIL lat_after_data got=%h want=55", bus.out_data); end
        bus.out_rdy = 1'b1;
        cyc();
        bus.out_rdy = 1'b0;
    endtask

    task automatic test_full_rw();
        bus.in_vld = 1'b1; bus.out_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = 32'h100 + 32'(i);
            cyc();
        end
        bus.in_data = 32'h200; bus.out_rdy = 1'b1;
        #1;
        total++; if (bus.in_rdy !== 1'b0) begin bad++; $display("FAIL frw_full_rdy got=%b want=0", bus.in_rdy); end
        cyc();
        total++; if (bus.count !== 4'd7) begin bad++; $display("FAIL frw_count7 got=%0d want=7", bus.count); end
        total++; if (bus.in_rdy !== 1'b1) begin bad++; $display("FAIL frw_in_rdy got=%b want=1", bus.in_rdy); end
        total++; if (bus.out_data !== 32'h101) begin bad++; $display("FAIL frw_head got=%h want=101", bus.out_data); end
        bus.out_rdy = 1'b0;
        cyc();
        bus.in_vld = 1'b0;
        total++; if (bus.count !== 4'd8) begin bad++; $display("FAIL frw_count8 got=%0d want=8", bus.count); end
        bus.out_rdy = 1'b1;
        for (int i = 1; i < 9; i++) begin
            logic [31:0] exp;
            exp = (i == 8) ? 32'h200 : 32'h100 + 32'(i);
            total++; if (bus.out_data !== exp) begin bad++; $display("FAIL frw_drain[%0d] got=%h want=%h", i, bus.out_data, exp); end
            cyc();
        end
        bus.out_rdy = 1'b0;
        total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL frw_empty got=%b want=0", bus.out_vld); end
    endtask

    task automatic test_back_to_back();
        bus.in_vld = 1'b1; bus.out_rdy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.in_data = 32'h300 + 32'(k);
            cyc();
            total++; if (bus.count !== 4'd1) begin bad++; $display("FAIL b2b_count[%0d] got=%0d want=1", k, bus.count); end
            total++; if (bus.out_data !== 32'h300 + 32'(k)) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", k, bus.out_data, 32'h300 + 32'(k)); end
        end
        bus.in_vld = 1'b0;
        cyc();
        bus.out_rdy = 1'b0;
        total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL b2b_final_count got=%0d want=0", bus.count); end
    endtask

    task automatic test_clr();
        bus.in_vld = 1'b1; bus.out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = 32'h400 + 32'(i);
            cyc();
        end
        total++; if (bus.count !== 4'd3) begin bad++; $display("FAIL clr_pre_count got=%0d want=3", bus.count); end
        bus.clr = 1'b1; bus.in_data = 32'h4FF;
        cyc();
        bus.clr = 1'b0; bus.in_vld = 1'b0;
        total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL clr_count got=%0d want=0", bus.count); end
        total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL clr_out_vld got=%b want=0", bus.out_vld); end
        bus.in_vld = 1'b1; bus.in_data = 32'h4AA;
        cyc();
        bus.in_vld = 1'b0;
        total++; if (bus.count !== 4'd1) begin bad++; $display("FAIL clr_post_count got=%0d want=1", bus.count); end
        total++; if (bus.out_data !== 32'h4AA) begin bad++; $display("FAIL clr_post_data got=%h want=4aa", bus.out_data); end
        bus.out_rdy = 1'b1;
        cyc();
        bus.out_rdy = 1'b0;
        total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL clr_final_vld got=%b want=0", bus.out_vld); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_midstream_reset();
        test_fill_drain();
        test_latency();
        test_full_rw();
        test_back_to_back();
        test_clr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
